// File: rtl/iob_native_sram.sv
// iob_native_sram: single-port SRAM behind a native valid/ready bus.
// Each access is latched in IDLE. It then spends WAIT_CYC cycles in WAIT and
// completes with a one-cycle ready pulse in RESP.
// rdata is loaded when the FSM enters RESP, so a write returns the pre-write word.
// Byte writes commit at the clock edge that ends RESP.
// Optional feature macro: NATIVE_SRAM_WPROT_EN. It adds the wprot input and
// the WPROT_TOP parameter, which drop writes to the low protected region.
module iob_native_sram #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int WAIT_CYC   = 1
`ifdef NATIVE_SRAM_WPROT_EN
    ,
    parameter int WPROT_TOP  = 256
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
`ifdef NATIVE_SRAM_WPROT_EN
    input  logic                wprot,
`endif
    output logic [DATA_W-1:0]   rdata,
    output logic                ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] WAIT_C = 4'(WAIT_CYC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [DATA_W-1:0]     mem [0:(2**MEM_ADDR_W)-1];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rdata_q;
    logic                  ready_q;
    logic                  enter_resp_s;
    logic                  wr_en_s;
    logic                  unused_addr_s;

    // The byte offset and the address bits above the word index are ignored,
    // so accesses wrap modulo the memory size.
    assign unused_addr_s = ^address;

    // Next-state logic: latch the request in IDLE, count wait states, then respond.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    idx_d   = address[MEM_ADDR_W+1:2];
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    cnt_d   = WAIT_C;
                    state_d = (WAIT_C != 4'd0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decode the memory-side events: enter RESP, and commit the write at the end of RESP.
    always_comb begin
        enter_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
`ifdef NATIVE_SRAM_WPROT_EN
        if (wprot && (32'(idx_q) < 32'(WPROT_TOP))) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = (state_q == ST_RESP) && (|wstrb_q);
        end
`else
        wr_en_s = (state_q == ST_RESP) && (|wstrb_q);
`endif
    end

    // Control registers and the response path. An aborted access leaves memory alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= enter_resp_s;
            if (enter_resp_s) begin
                rdata_q <= mem[idx_d];
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    // Storage array with byte-enable writes. Reset does not clear it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (wr_en_s && wstrb_q[i]) begin
                mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_iob_native_sram.sv
// Directed self-checking bench for iob_native_sram.
// It uses three instances: WAIT_CYC=1 (main), WAIT_CYC=0 (back-to-back) and WAIT_CYC=3 (reset abort).
module tb_iob_native_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          chk_n = 0;
    int          fail_n = 0;

    logic        v1 = 1'b0, req0 = 1'b0, v3 = 1'b0, v0;
    logic [31:0] a1 = '0, a0 = '0, a3 = '0;
    logic [31:0] wd1 = '0, wd0 = '0, wd3 = '0;
    logic [3:0]  ws1 = '0, ws0 = '0, ws3 = '0;
    logic [31:0] rd1, rd0, rd3;
    logic        rdy1, rdy0, rdy3;
`ifdef NATIVE_SRAM_WPROT_EN
    logic        wp1 = 1'b0;
`endif

    always #5 clk = ~clk;

    // The initiator for the zero-wait instance gates valid with ready.
    assign v0 = req0 & ~rdy0;

    iob_native_sram #(.WAIT_CYC(1)) u1 (.clk(clk), .rst(rst), .valid(v1), .address(a1),
        .wdata(wd1), .wstrb(ws1),
`ifdef NATIVE_SRAM_WPROT_EN
        .wprot(wp1),
`endif
        .rdata(rd1), .ready(rdy1));
    iob_native_sram #(.WAIT_CYC(0)) u0 (.clk(clk), .rst(rst), .valid(v0), .address(a0),
        .wdata(wd0), .wstrb(ws0),
`ifdef NATIVE_SRAM_WPROT_EN
        .wprot(1'b0),
`endif
        .rdata(rd0), .ready(rdy0));
    iob_native_sram #(.WAIT_CYC(3)) u3 (.clk(clk), .rst(rst), .valid(v3), .address(a3),
        .wdata(wd3), .wstrb(ws3),
`ifdef NATIVE_SRAM_WPROT_EN
        .wprot(1'b0),
`endif
        .rdata(rd3), .ready(rdy3));

    function automatic logic get_rdy(input int sel);
        case (sel)
            0: return rdy0;
            1: return rdy1;
            default: return rdy3;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        case (sel)
            0: return rd0;
            1: return rd1;
            default: return rd3;
        endcase
    endfunction

    task automatic set_req(input int sel, input logic v, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws);
        case (sel)
            0: begin req0 = v; a0 = a; wd0 = wd; ws0 = ws; end
            1: begin v1 = v; a1 = a; wd1 = wd; ws1 = ws; end
            default: begin v3 = v; a3 = a; wd3 = wd; ws3 = ws; end
        endcase
    endtask

    // One transaction, entered and left on a falling edge.
    // lat counts the cycles from valid to ready (99 means a timeout).
    // rdy_after is ready one cycle after the pulse.
    task automatic acc(input int sel, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd, output int lat,
                       output logic rdy_after);
        set_req(sel, 1'b1, a, wd, ws);
        lat = 0;
        do begin
            @(posedge clk); @(negedge clk);
            lat++;
            set_req(sel, 1'b0, a, wd, ws);
        end while (!get_rdy(sel) && lat < 20);
        rd = get_rd(sel);
        if (!get_rdy(sel)) lat = 99;
        @(negedge clk);
        rdy_after = get_rdy(sel);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk_n++; if (rdy1 !== 1'b0) begin fail_n++; $display("FAIL reset_ready1 got=%b exp=0", rdy1); end
        chk_n++; if (rd1 !== 32'h0) begin fail_n++; $display("FAIL reset_rdata1 got=%h exp=0", rd1); end
        chk_n++; if (rdy0 !== 1'b0 || rdy3 !== 1'b0) begin fail_n++; $display("FAIL reset_ready03 got=%b%b exp=00", rdy0, rdy3); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; int lat; logic ra;
        acc(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ra);
        chk_n++; if (lat != 2) begin fail_n++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        chk_n++; if (ra !== 1'b0) begin fail_n++; $display("FAIL wr_pulse_width got=%b exp=0", ra); end
        acc(1, 32'h10, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (lat != 2) begin fail_n++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        chk_n++; if (rd !== 32'hDEADBEEF) begin fail_n++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_partial();
        logic [31:0] rd; int lat; logic ra;
        acc(1, 32'h10, 32'h0000AA00, 4'h2, rd, lat, ra);
        chk_n++; if (rd !== 32'hDEADBEEF) begin fail_n++; $display("FAIL rbw_data got=%h exp=deadbeef", rd); end
        acc(1, 32'h10, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (rd !== 32'hDEADAAEF) begin fail_n++; $display("FAIL partial_data got=%h exp=deadaaef", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; int lat; logic ra;
        acc(1, 32'h4000, 32'h12345678, 4'hF, rd, lat, ra);
        acc(1, 32'h0000, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (rd !== 32'h12345678) begin fail_n++; $display("FAIL wrap_data got=%h exp=12345678", rd); end
        acc(1, 32'h0003, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (rd !== 32'h12345678) begin fail_n++; $display("FAIL byteoff_data got=%h exp=12345678", rd); end
        repeat (3) @(negedge clk);
        chk_n++; if (rd1 !== 32'h12345678 || rdy1 !== 1'b0) begin fail_n++; $display("FAIL rdata_hold got=%h/%b exp=12345678/0", rd1, rdy1); end
    endtask

    // Request fields that change during WAIT/RESP must not affect the transaction.
    task automatic test_ignore_fields();
        logic [31:0] rd; int lat; logic ra;
        set_req(1, 1'b1, 32'h10, 32'h0, 4'h0);
        @(posedge clk); @(negedge clk);
        set_req(1, 1'b1, 32'h0, 32'h0, 4'hF);
        @(posedge clk); @(negedge clk);
        chk_n++; if (rdy1 !== 1'b1 || rd1 !== 32'hDEADAAEF) begin fail_n++; $display("FAIL ignore_resp got=%b/%h exp=1/deadaaef", rdy1, rd1); end
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        acc(1, 32'h0, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (rd !== 32'h12345678) begin fail_n++; $display("FAIL ignore_nowrite got=%h exp=12345678", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; logic ra; logic exp;
        acc(0, 32'h0, 32'hA5A5A5A5, 4'hF, rd, lat, ra);
        chk_n++; if (lat != 1 || ra !== 1'b0) begin fail_n++; $display("FAIL w0_latency got=%0d/%b exp=1/0", lat, ra); end
        set_req(0, 1'b1, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            exp = (i % 2 == 0);
            chk_n++; if (rdy0 !== exp) begin fail_n++; $display("FAIL b2b_ready_%0d got=%b exp=%b", i, rdy0, exp); end
            if (exp) begin
                chk_n++; if (rd0 !== 32'hA5A5A5A5) begin fail_n++; $display("FAIL b2b_data_%0d got=%h exp=a5a5a5a5", i, rd0); end
            end
            if (i == 7) req0 = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        chk_n++; if (rdy0 !== 1'b0) begin fail_n++; $display("FAIL b2b_stop got=%b exp=0", rdy0); end
    endtask

`ifdef NATIVE_SRAM_WPROT_EN
    task automatic test_wprot();
        logic [31:0] rd; int lat; logic ra;
        wp1 = 1'b0;
        acc(1, 32'h14, 32'h5555AAAA, 4'hF, rd, lat, ra);
        acc(1, 32'h4B0, 32'h0, 4'hF, rd, lat, ra);
        wp1 = 1'b1;
        acc(1, 32'h14, 32'hFFFFFFFF, 4'hF, rd, lat, ra);
        chk_n++; if (lat != 2) begin fail_n++; $display("FAIL wprot_ack got=%0d exp=2", lat); end
        acc(1, 32'h14, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (rd !== 32'h5555AAAA) begin fail_n++; $display("FAIL wprot_drop got=%h exp=5555aaaa", rd); end
        acc(1, 32'h4B0, 32'hFFFFFFFF, 4'hF, rd, lat, ra);
        acc(1, 32'h4B0, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (rd !== 32'hFFFFFFFF) begin fail_n++; $display("FAIL wprot_commit got=%h exp=ffffffff", rd); end
        wp1 = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic ra;
        acc(3, 32'h20, 32'h0BADF00D, 4'hF, rd, lat, ra);
        chk_n++; if (lat != 4) begin fail_n++; $display("FAIL w3_latency got=%0d exp=4", lat); end
        acc(3, 32'h20, 32'h0, 4'h0, rd, lat, ra);
        set_req(3, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); @(negedge clk);
        set_req(3, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        chk_n++; if (rdy3 !== 1'b0 || rd3 !== 32'h0) begin fail_n++; $display("FAIL rst_async got=%b/%h exp=0/0", rdy3, rd3); end
        @(negedge clk);
        @(negedge clk);
        chk_n++; if (rdy3 !== 1'b0) begin fail_n++; $display("FAIL rst_hold got=%b exp=0", rdy3); end
        rst = 1'b0;
        acc(3, 32'h20, 32'h0, 4'h0, rd, lat, ra);
        chk_n++; if (lat != 4) begin fail_n++; $display("FAIL post_rst_latency got=%0d exp=4", lat); end
        chk_n++; if (rd !== 32'h0BADF00D) begin fail_n++; $display("FAIL rst_no_write got=%h exp=0badf00d", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_wrap();
        test_ignore_fields();
        test_back_to_back();
`ifdef NATIVE_SRAM_WPROT_EN
        test_wprot();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
